// File: rtl/ysyx_2022040010_fetch_ctrl_if.sv
// Fetch controller bus bundle: redirect, decode handshake and instruction-memory port.
interface ysyx_2022040010_fetch_ctrl_if;
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CNTW = 32;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_inst;
  logic [CNTW-1:0] fetch_cnt;

  // Fetch controller side
  modport master (
    input  redirect_valid, redirect_pc, id_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_inst, fetch_cnt
  );

  // Memory / decode / redirect source side
  modport slave (
    output redirect_valid, redirect_pc, id_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, fetch_cnt
  );
endinterface

// File: rtl/ysyx_2022040010_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem read, presents the
// fetched word to decode, and handles flush/redirect including draining a
// response that is already in flight.
module ysyx_2022040010_fetch_ctrl #(
  parameter logic [63:0] INIT_PC = 64'h0000_0000_8000_0000
) (
  input  logic                           clk,
  input  logic                           rst,
  ysyx_2022040010_fetch_ctrl_if.master   bus
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned CNTW = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_n;
  logic [XLEN-1:0] redirect_target;
  logic            req_n;
  logic [XLEN-1:0] addr_n;
  logic            valid_n;
  logic [XLEN-1:0] if_pc_n;
  logic [ILEN-1:0] inst_n;
  logic [CNTW-1:0] cnt_n;

  // Redirect targets are forced to 4-byte alignment
  assign redirect_target = {bus.redirect_pc[XLEN-1:2], 2'b00};

  // State, pc and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= INIT_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= '0;
      bus.if_valid  <= 1'b0;
      bus.if_pc     <= '0;
      bus.if_inst   <= '0;
      bus.fetch_cnt <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      bus.imem_req  <= req_n;
      bus.imem_addr <= addr_n;
      bus.if_valid  <= valid_n;
      bus.if_pc     <= if_pc_n;
      bus.if_inst   <= inst_n;
      bus.fetch_cnt <= cnt_n;
    end
  end

  // Next state and next output values; redirect overrides everything past IDLE
  always_comb begin
    state_n = state;
    pc_n    = pc;
    req_n   = 1'b0;
    addr_n  = bus.imem_addr;
    valid_n = bus.if_valid;
    if_pc_n = bus.if_pc;
    inst_n  = bus.if_inst;
    cnt_n   = bus.fetch_cnt;

    if (state == IDLE) begin
      state_n = REQ;
    end else if (bus.redirect_valid) begin
      pc_n    = redirect_target;
      valid_n = 1'b0;
      // A response still owed by memory must be swallowed before reissuing
      if ((state == WAIT || state == DRAIN) && !bus.imem_rvalid) begin
        state_n = DRAIN;
      end else begin
        state_n = REQ;
      end
    end else begin
      case (state)
        REQ: begin
          state_n = WAIT;
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            inst_n  = bus.imem_rdata;
            if_pc_n = pc;
            pc_n    = pc + XLEN'(4);
            valid_n = 1'b1;
            state_n = VALID;
          end
        end
        VALID: begin
          if (bus.id_ready) begin
            valid_n = 1'b0;
            cnt_n   = bus.fetch_cnt + CNTW'(1);
            state_n = REQ;
          end
        end
        DRAIN: begin
          if (bus.imem_rvalid) begin
            state_n = REQ;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    // Request strobe and address are registered alongside entry into REQ
    if (state_n == REQ) begin
      req_n  = 1'b1;
      addr_n = pc_n;
    end
  end
endmodule

// File: tb/tb_ysyx_2022040010_fetch_ctrl.sv
// Self-checking bench for the fetch controller: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_ysyx_2022040010_fetch_ctrl;
  localparam logic [63:0] INIT_PC = 64'h0000_0000_8000_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ysyx_2022040010_fetch_ctrl_if bus();

  ysyx_2022040010_fetch_ctrl #(.INIT_PC(INIT_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks whether a request is being issued, whether a
  // response is owed (and whether it is wanted), and what decode is shown.
  logic        m_started;
  logic        m_issue;
  logic        m_owed;
  logic        m_want;
  logic        m_show;
  logic [63:0] m_pc;
  logic [63:0] e_ifpc;
  logic [31:0] e_inst;
  logic [31:0] e_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0;
    m_issue   = 1'b0;
    m_owed    = 1'b0;
    m_want    = 1'b0;
    m_show    = 1'b0;
    m_pc      = INIT_PC;
    e_ifpc    = '0;
    e_inst    = '0;
    e_cnt     = '0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rdata, input logic rd,
                            input logic [63:0] rpc, input logic idr);
    logic [63:0] tgt;
    tgt = rpc & ~64'h3;
    if (!m_started) begin
      m_started = 1'b1;
      m_issue   = 1'b1;
    end else if (m_issue) begin
      if (rd) m_pc = tgt;
      else begin
        m_issue = 1'b0;
        m_owed  = 1'b1;
        m_want  = 1'b1;
      end
    end else if (m_owed) begin
      if (rd) begin
        m_pc   = tgt;
        m_want = 1'b0;
      end
      if (rv) begin
        m_owed = 1'b0;
        if (m_want) begin
          e_ifpc = m_pc;
          e_inst = rdata;
          m_pc   = m_pc + 64'd4;
          m_show = 1'b1;
        end else begin
          m_issue = 1'b1;
        end
      end
    end else if (m_show) begin
      if (rd) begin
        m_pc    = tgt;
        m_show  = 1'b0;
        m_issue = 1'b1;
      end else if (idr) begin
        e_cnt   = e_cnt + 32'd1;
        m_show  = 1'b0;
        m_issue = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", 64'(bus.imem_req), 64'(m_issue));
    if (m_issue) check("imem_addr", bus.imem_addr, m_pc);
    check("if_valid", 64'(bus.if_valid), 64'(m_show));
    if (m_show) begin
      check("if_pc", bus.if_pc, e_ifpc);
      check("if_inst", 64'(bus.if_inst), 64'(e_inst));
    end
    check("fetch_cnt", 64'(bus.fetch_cnt), 64'(e_cnt));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after it
  task automatic tick(input logic rv, input logic [31:0] rdata, input logic rd,
                      input logic [63:0] rpc, input logic idr);
    bus.imem_rvalid    = rv;
    bus.imem_rdata     = rdata;
    bus.redirect_valid = rd;
    bus.redirect_pc    = rpc;
    bus.id_ready       = idr;
    @(posedge clk);
    model_step(rv, rdata, rd, rpc, idr);
    #1;
    compare_all();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"},   64'(bus.imem_req),  64'd0);
    check({tag, "_addr"},  bus.imem_addr,      64'd0);
    check({tag, "_valid"}, 64'(bus.if_valid),  64'd0);
    check({tag, "_pc"},    bus.if_pc,          64'd0);
    check({tag, "_inst"},  64'(bus.if_inst),   64'd0);
    check({tag, "_cnt"},   64'(bus.fetch_cnt), 64'd0);
  endtask

  logic [63:0] held_pc;
  logic [31:0] held_inst;
  logic [31:0] held_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst                = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
    #12;
    check_zero("reset");
    rst = 1'b1;

    // Back-to-back fetches with 1-cycle memory latency
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("seq_addr", bus.imem_addr, INIT_PC + 64'(4 * k));
      tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
      tick(1'b1, 32'h1000_0013 + 32'(k), 1'b0, 64'h0, 1'b1);
      check("seq_ifpc", bus.if_pc, INIT_PC + 64'(4 * k));
      check("seq_inst", 64'(bus.if_inst), 64'(32'h1000_0013 + 32'(k)));
      tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    end
    check("seq_cnt3", 64'(bus.fetch_cnt), 64'd3);

    // Decode stall: presented instruction held, no new request, stray rvalid ignored
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick(1'b1, 32'hdead_beef, 1'b0, 64'h0, 1'b0);
    held_pc   = bus.if_pc;
    held_inst = bus.if_inst;
    for (int k = 0; k < 5; k++) begin
      tick(1'(k % 2), 32'h1234_5678, 1'b0, 64'h0, 1'b0);
      check("stall_valid", 64'(bus.if_valid), 64'd1);
      check("stall_pc", bus.if_pc, held_pc);
      check("stall_inst", 64'(bus.if_inst), 64'(held_inst));
      check("stall_req", 64'(bus.imem_req), 64'd0);
      check("stall_cnt", 64'(bus.fetch_cnt), 64'd3);
    end
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    check("stall_cnt4", 64'(bus.fetch_cnt), 64'd4);

    // Redirect while waiting, response arrives two cycles later and is dropped
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 64'h0000_0000_8000_1003, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    check("drain_noreq", 64'(bus.imem_req), 64'd0);
    tick(1'b1, 32'hbad0_bad0, 1'b0, 64'h0, 1'b1);
    check("drain_valid", 64'(bus.if_valid), 64'd0);
    check("drain_addr", bus.imem_addr, 64'h0000_0000_8000_1000);

    // Redirect coinciding with rvalid: data discarded, reissue at target
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick(1'b1, 32'hbad1_bad1, 1'b1, 64'h0000_0000_8000_2000, 1'b0);
    check("rdrv_valid", 64'(bus.if_valid), 64'd0);
    check("rdrv_req", 64'(bus.imem_req), 64'd1);
    check("rdrv_addr", bus.imem_addr, 64'h0000_0000_8000_2000);
    // Redirect together with id_ready in VALID: no transfer counted
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick(1'b1, 32'h0000_0093, 1'b0, 64'h0, 1'b0);
    held_cnt = bus.fetch_cnt;
    tick(1'b0, 32'h0, 1'b1, 64'h0000_0000_8000_3000, 1'b1);
    check("rdir_cnt", 64'(bus.fetch_cnt), 64'(held_cnt));
    check("rdir_addr", bus.imem_addr, 64'h0000_0000_8000_3000);

    // PC wraps past the top of the address space
    tick(1'b0, 32'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    tick(1'b1, 32'h0000_0113, 1'b0, 64'h0, 1'b0);
    check("wrap_ifpc", bus.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);
    check("wrap_addr", bus.imem_addr, 64'h0);

    // Asynchronous reset during WAIT, then a stale response after release
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    rst = 1'b0;
    #1;
    check_zero("async");
    model_reset();
    #1;
    rst = 1'b1;
    tick(1'b1, 32'hbad2_bad2, 1'b0, 64'h0, 1'b0);
    check("rst_addr", bus.imem_addr, INIT_PC);
    tick(1'b1, 32'hbad3_bad3, 1'b0, 64'h0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b0);
    check("rst_stale", 64'(bus.if_valid), 64'd0);
    tick(1'b1, 32'h0000_0193, 1'b0, 64'h0, 1'b0);
    check("rst_ifpc", bus.if_pc, INIT_PC);
    tick(1'b0, 32'h0, 1'b0, 64'h0, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      tick(1'($urandom_range(0, 2) == 0), 32'($urandom),
           1'($urandom_range(0, 15) == 0), {32'($urandom), 32'($urandom)},
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
